vga_capture: RTL and testbench

Receive-side counterpart of the VGA output path: samples a VGA pixel stream (syncs, blank, 8-bit RGB) on the pixel clock, recovers pixel coordinates, and checks that the frame geometry matches the configured mode. Once locked, it emits a decimated, colour-reduced pixel-write stream (8-bit X/Y, 3-bit R/G/B plus a write strobe), the same write format the drawing side uses to feed the framebuffer. Used for loopback test of the VGA controller and for capture into a second framebuffer.

---
 rtl/vga_pkg.sv | 31 +++
 rtl/vga_edge_det.sv | 25 ++
 rtl/vga_capture.sv | 205 ++++++++++++++++++++
 tb/tb_vga_capture.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants, types and small helpers for the VGA capture path.
// Write-port widths match the drawing side's framebuffer write format.
package vga_pkg;

  localparam int SVGA_H_ACTIVE = 800;
  localparam int SVGA_V_ACTIVE = 600;
  localparam int COORD_W       = 8;
  localparam int COLOR_W       = 3;
  localparam int XCNT_W        = 11;
  localparam int YCNT_W        = 10;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  // Counters stick at all-ones instead of wrapping so runaway lines/frames still fail.
  function automatic logic [XCNT_W-1:0] xcnt_inc(input logic [XCNT_W-1:0] v);
    return (&v) ? v : v + {{(XCNT_W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [YCNT_W-1:0] ycnt_inc(input logic [YCNT_W-1:0] v);
    return (&v) ? v : v + {{(YCNT_W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [COLOR_W-1:0] colour_msb(input logic [7:0] c);
    return c[7:8-COLOR_W];
  endfunction

endpackage

// File: rtl/vga_edge_det.sv
// Edge detector: pulses while i_d has just moved into level POL. Holds the
// previous sample internally; the pulse itself is combinational from it.
module vga_edge_det #(
  parameter logic POL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_edge
);

  logic r_prev;

  // Reset to POL so that no edge is reported straight out of reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prev <= POL;
    end else begin
      r_prev <= i_d;
    end
  end

  assign o_edge = (i_d == POL) && (r_prev != POL);

endmodule

// File: rtl/vga_capture.sv
// VGA receive side: recovers pixel coordinates, verifies frame geometry and,
// once locked, emits a decimated, colour-reduced pixel-write stream.
module vga_capture
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE  = SVGA_H_ACTIVE,
  parameter int   V_ACTIVE  = SVGA_V_ACTIVE,
  parameter int   DEC_SHIFT = 2,
  parameter logic VS_POL    = 1'b1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               VGA_VS,
  input  logic               VGA_BLANK_N,
  input  logic [7:0]         VGA_R,
  input  logic [7:0]         VGA_G,
  input  logic [7:0]         VGA_B,
  output logic               WE,
  output logic [COORD_W-1:0] X,
  output logic [COORD_W-1:0] Y,
  output logic [COLOR_W-1:0] R,
  output logic [COLOR_W-1:0] G,
  output logic [COLOR_W-1:0] B,
  output logic               FRAME_START,
  output logic               LOCKED,
  output logic               ERR
);

  localparam logic [XCNT_W-1:0] H_LEN = XCNT_W'(H_ACTIVE);
  localparam logic [YCNT_W-1:0] V_LEN = YCNT_W'(V_ACTIVE);

  logic               r_vs1;
  logic               r_blank1;
  logic [COLOR_W-1:0] r_r1;
  logic [COLOR_W-1:0] r_g1;
  logic [COLOR_W-1:0] r_b1;
  logic [XCNT_W-1:0]  r_xcnt;
  logic [YCNT_W-1:0]  r_ycnt;
  state_t             r_state;
  logic               r_we;
  logic               r_fs;
  logic               r_locked;
  logic               r_err;
  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  logic [COLOR_W-1:0] r_r;
  logic [COLOR_W-1:0] r_g;
  logic [COLOR_W-1:0] r_b;

  logic               w_vs_start;
  logic               w_line_end;
  logic               w_dec_hit;
  logic               w_in_range;
  logic [YCNT_W-1:0]  w_ycnt_eff;
  logic               w_chk_fail;
  state_t             w_state_nxt;
  logic               w_err_nxt;
  logic               w_fs_nxt;
  logic               w_we_nxt;

  // Stage 1: single input register; only the colour MSBs are kept.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_vs1    <= ~VS_POL;
      r_blank1 <= 1'b0;
      r_r1     <= {COLOR_W{1'b0}};
      r_g1     <= {COLOR_W{1'b0}};
      r_b1     <= {COLOR_W{1'b0}};
    end else begin
      r_vs1    <= VGA_VS;
      r_blank1 <= VGA_BLANK_N;
      r_r1     <= colour_msb(VGA_R);
      r_g1     <= colour_msb(VGA_G);
      r_b1     <= colour_msb(VGA_B);
    end
  end

  vga_edge_det #(.POL(VS_POL)) u_vs_edge (
    .i_clk  (CLK),
    .i_rst  (RST),
    .i_d    (r_vs1),
    .o_edge (w_vs_start)
  );

  vga_edge_det #(.POL(1'b0)) u_blank_edge (
    .i_clk  (CLK),
    .i_rst  (RST),
    .i_d    (r_blank1),
    .o_edge (w_line_end)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_xcnt <= {XCNT_W{1'b0}};
      r_ycnt <= {YCNT_W{1'b0}};
    end else begin
      if (w_line_end) begin
        r_xcnt <= {XCNT_W{1'b0}};
      end else if (r_blank1) begin
        r_xcnt <= xcnt_inc(r_xcnt);
      end
      if (w_vs_start) begin
        r_ycnt <= {YCNT_W{1'b0}};
      end else if (w_line_end) begin
        r_ycnt <= ycnt_inc(r_ycnt);
      end
    end
  end

  assign w_dec_hit  = (r_xcnt[DEC_SHIFT-1:0] == {DEC_SHIFT{1'b0}}) &&
                      (r_ycnt[DEC_SHIFT-1:0] == {DEC_SHIFT{1'b0}});
  assign w_in_range = (r_xcnt < H_LEN) && (r_ycnt < V_LEN);

  // A coincident line_end is counted before the frame length is judged.
  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = 1'b0;
    w_ycnt_eff  = r_ycnt;
    if (w_line_end) begin
      w_ycnt_eff = ycnt_inc(r_ycnt);
    end else begin
      w_ycnt_eff = r_ycnt;
    end
    w_chk_fail = (w_line_end && (r_xcnt != H_LEN)) ||
                 (w_vs_start && (w_ycnt_eff != V_LEN));
    case (r_state)
      ST_SEARCH: begin
        if (w_vs_start) begin
          w_state_nxt = ST_MEASURE;
        end else begin
          w_state_nxt = ST_SEARCH;
        end
      end
      ST_MEASURE: begin
        if (w_chk_fail) begin
          w_state_nxt = ST_SEARCH;
          w_err_nxt   = 1'b1;
        end else if (w_vs_start) begin
          w_state_nxt = ST_LOCKED;
        end else begin
          w_state_nxt = ST_MEASURE;
        end
      end
      ST_LOCKED: begin
        if (w_chk_fail) begin
          w_state_nxt = ST_SEARCH;
          w_err_nxt   = 1'b1;
        end else begin
          w_state_nxt = ST_LOCKED;
        end
      end
      default: begin
        w_state_nxt = ST_SEARCH;
      end
    endcase
    w_fs_nxt = w_vs_start && (w_state_nxt == ST_LOCKED);
    w_we_nxt = (r_state == ST_LOCKED) && r_blank1 && w_dec_hit && w_in_range;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_SEARCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Output register; coordinates and colour hold between write strobes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_we     <= 1'b0;
      r_fs     <= 1'b0;
      r_locked <= 1'b0;
      r_err    <= 1'b0;
      r_x      <= {COORD_W{1'b0}};
      r_y      <= {COORD_W{1'b0}};
      r_r      <= {COLOR_W{1'b0}};
      r_g      <= {COLOR_W{1'b0}};
      r_b      <= {COLOR_W{1'b0}};
    end else begin
      r_we     <= w_we_nxt;
      r_fs     <= w_fs_nxt;
      r_locked <= (w_state_nxt == ST_LOCKED);
      r_err    <= w_err_nxt;
      if (w_we_nxt) begin
        r_x <= COORD_W'(r_xcnt >> DEC_SHIFT);
        r_y <= COORD_W'(r_ycnt >> DEC_SHIFT);
        r_r <= r_r1;
        r_g <= r_g1;
        r_b <= r_b1;
      end
    end
  end

  assign WE          = r_we;
  assign X           = r_x;
  assign Y           = r_y;
  assign R           = r_r;
  assign G           = r_g;
  assign B           = r_b;
  assign FRAME_START = r_fs;
  assign LOCKED      = r_locked;
  assign ERR         = r_err;

endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture: a frame table drives a reduced-size mode into a
// positive-VS and an inverted-VS instance, checked against a scoreboard.
module tb_vga_capture;

  localparam int H  = 32;
  localparam int V  = 12;
  localparam int DS = 2;
  localparam int HB = 8;
  localparam int LT = H + HB;
  localparam int NF = 12;

  typedef struct {
    int         nlines;
    int         short_line;
    int         rst_line;
    int         rst_px;
    bit         rand_col;
    logic [7:0] cr;
    logic [7:0] cg;
    logic [7:0] cb;
    int         exp_we;
    int         exp_err;
    int         exp_fs;
    int         exp_locked;
  } frame_t;

  typedef struct {
    int         cyc;
    logic [7:0] x;
    logic [7:0] y;
    logic [2:0] r;
    logic [2:0] g;
    logic [2:0] b;
  } wr_t;

  typedef struct {
    int   cyc;
    logic val;
  } lk_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vs = 1'b0;
  logic       vs_n;
  logic       blank_n = 1'b0;
  logic [7:0] pr = 8'd0;
  logic [7:0] pg = 8'd0;
  logic [7:0] pb = 8'd0;

  logic       we1, fs1, lk1, er1, we0, fs0, lk0, er0;
  logic [7:0] x1, y1, x0, y0;
  logic [2:0] r1, g1, b1, r0, g0, b0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  wr_t wq[$];
  int  errq[$];
  int  fsq[$];
  lk_t lkq[$];

  int   m_state = 0;
  int   mx = 0;
  int   my = 0;
  logic pv = 1'b0;
  logic pbl = 1'b0;

  bit   mon_en = 1'b0;
  logic exp_lock = 1'b0;
  wr_t  last_wr;
  int   cnt_we = 0;
  int   cnt_err = 0;
  int   cnt_fs = 0;

  assign vs_n = ~vs;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vga_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .DEC_SHIFT(DS), .VS_POL(1'b1)) dut1 (
    .CLK(clk), .RST(rst), .VGA_VS(vs), .VGA_BLANK_N(blank_n),
    .VGA_R(pr), .VGA_G(pg), .VGA_B(pb),
    .WE(we1), .X(x1), .Y(y1), .R(r1), .G(g1), .B(b1),
    .FRAME_START(fs1), .LOCKED(lk1), .ERR(er1)
  );

  vga_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .DEC_SHIFT(DS), .VS_POL(1'b0)) dut0 (
    .CLK(clk), .RST(rst), .VGA_VS(vs_n), .VGA_BLANK_N(blank_n),
    .VGA_R(pr), .VGA_G(pg), .VGA_B(pb),
    .WE(we0), .X(x0), .Y(y0), .R(r0), .G(g0), .B(b0),
    .FRAME_START(fs0), .LOCKED(lk0), .ERR(er0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Drive one pixel clock of input and push what the DUT must produce 2 cycles later.
  task automatic drive(input logic r_in, input logic v_in, input logic b_in,
                       input logic [7:0] cr, input logic [7:0] cg, input logic [7:0] cb);
    bit  le, vsr, fail;
    int  nxt;
    wr_t w;
    lk_t t;
    @(posedge clk);
    #1;
    rst = r_in; vs = v_in; blank_n = b_in; pr = cr; pg = cg; pb = cb;
    if (r_in) begin
      while (wq.size() > 0 && wq[wq.size()-1].cyc > cyc) void'(wq.pop_back());
      while (errq.size() > 0 && errq[errq.size()-1] > cyc) void'(errq.pop_back());
      while (fsq.size() > 0 && fsq[fsq.size()-1] > cyc) void'(fsq.pop_back());
      while (lkq.size() > 0 && lkq[lkq.size()-1].cyc > cyc) void'(lkq.pop_back());
      t.cyc = cyc + 1; t.val = 1'b0; lkq.push_back(t);
      m_state = 0; mx = 0; my = 0; pv = 1'b0; pbl = 1'b0;
    end else begin
      le = pbl && !b_in;
      vsr = !pv && v_in;
      fail = 1'b0;
      if (b_in) begin
        if (m_state == 2 && mx % 4 == 0 && my % 4 == 0 && mx < H && my < V) begin
          w.cyc = cyc + 2; w.x = 8'(mx / 4); w.y = 8'(my / 4);
          w.r = cr[7:5]; w.g = cg[7:5]; w.b = cb[7:5];
          wq.push_back(w);
        end
        mx++;
      end
      if (le) begin
        if (m_state != 0 && mx != H) fail = 1'b1;
        mx = 0;
        my++;
      end
      if (vsr && m_state != 0 && my != V) fail = 1'b1;
      nxt = m_state;
      if (fail) begin
        nxt = 0;
        errq.push_back(cyc + 2);
      end else if (vsr) begin
        nxt = (m_state == 0) ? 1 : 2;
      end
      if (vsr && nxt == 2) fsq.push_back(cyc + 2);
      if ((nxt == 2) != (m_state == 2)) begin
        t.cyc = cyc + 2; t.val = (nxt == 2); lkq.push_back(t);
      end
      if (vsr) my = 0;
      m_state = nxt; pv = v_in; pbl = b_in;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"}, {we1, we0}, 2'b00);
    chk({tag, "_xy"}, {x1, y1, x0, y0}, 32'd0);
    chk({tag, "_rgb"}, {r1, g1, b1, r0, g0, b0}, 18'd0);
    chk({tag, "_flags"}, {fs1, lk1, er1, fs0, lk0, er0}, 6'd0);
  endtask

  task automatic gen_frame(input frame_t f);
    logic [7:0] cr, cg, cb;
    int len;
    for (int l = 0; l < f.nlines; l++) begin
      len = (l == f.short_line) ? H - 1 : H;
      for (int p = 0; p < len; p++) begin
        cr = f.rand_col ? 8'($urandom) : f.cr;
        cg = f.rand_col ? 8'($urandom) : f.cg;
        cb = f.rand_col ? 8'($urandom) : f.cb;
        if (l == f.rst_line && p == f.rst_px) begin
          drive(1'b1, 1'b0, 1'b1, cr, cg, cb);
          drive(1'b0, 1'b0, 1'b1, cr, cg, cb);
          @(negedge clk);
          chk_all_zero("midline_rst");
        end else begin
          drive(1'b0, 1'b0, 1'b1, cr, cg, cb);
        end
      end
      for (int p = 0; p < HB; p++) drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    end
    for (int p = 0; p < LT; p++) drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    for (int p = 0; p < LT; p++) drive(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
    for (int p = 0; p < LT; p++) drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
  endtask

  // Monitor: compares both instances with the scoreboard away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      bit  e_err, e_fs;
      wr_t e;
      while (lkq.size() > 0 && lkq[0].cyc <= cyc) begin
        exp_lock = lkq[0].val;
        void'(lkq.pop_front());
      end
      chk("locked", lk1, exp_lock);
      chk("locked_pol0", lk0, exp_lock);
      if (wq.size() > 0 && wq[0].cyc == cyc) begin
        e = wq.pop_front();
        last_wr = e;
        chk("we", {we1, we0}, 2'b11);
        chk("wr_xy", {x1, y1}, {e.x, e.y});
        chk("wr_rgb", {r1, g1, b1}, {e.r, e.g, e.b});
        chk("wr_pol0", {x0, y0, r0, g0, b0}, {e.x, e.y, e.r, e.g, e.b});
      end else if (we1 || we0) begin
        chk("we_unexpected", {we1, we0}, 2'b00);
      end
      e_err = (errq.size() > 0 && errq[0] == cyc);
      if (e_err) void'(errq.pop_front());
      if (e_err || er1 || er0) begin
        chk("err", {er1, er0}, {e_err, e_err});
        chk("lock_at_err", {lk1, lk0}, 2'b00);
      end
      e_fs = (fsq.size() > 0 && fsq[0] == cyc);
      if (e_fs) void'(fsq.pop_front());
      if (e_fs || fs1 || fs0) chk("frame_start", {fs1, fs0}, {e_fs, e_fs});
      cnt_we  += we1;
      cnt_err += er1;
      cnt_fs  += fs1;
    end
  end

  initial begin
    frame_t ft[NF];
    ft[0]  = '{12, -1, -1, -1, 1'b0, 8'hE0, 8'h20, 8'hFF,  0, 0, 0, 0};
    ft[1]  = '{12, -1, -1, -1, 1'b0, 8'hE0, 8'h20, 8'hFF,  0, 0, 1, 1};
    ft[2]  = '{12, -1, -1, -1, 1'b0, 8'hE0, 8'h20, 8'hFF, 24, 0, 1, 1};
    ft[3]  = '{12,  5, -1, -1, 1'b1, 8'h00, 8'h00, 8'h00, 16, 1, 0, 0};
    ft[4]  = '{12, -1, -1, -1, 1'b1, 8'h00, 8'h00, 8'h00,  0, 0, 1, 1};
    ft[5]  = '{13, -1, -1, -1, 1'b1, 8'h00, 8'h00, 8'h00, 24, 1, 0, 0};
    ft[6]  = '{12, -1, -1, -1, 1'b1, 8'h00, 8'h00, 8'h00,  0, 0, 0, 0};
    ft[7]  = '{12, -1, -1, -1, 1'b1, 8'h00, 8'h00, 8'h00,  0, 0, 1, 1};
    ft[8]  = '{12, -1, -1, -1, 1'b1, 8'h00, 8'h00, 8'h00, 24, 0, 1, 1};
    ft[9]  = '{12, -1,  1, 10, 1'b1, 8'h00, 8'h00, 8'h00,  8, 0, 0, 0};
    ft[10] = '{12, -1, -1, -1, 1'b1, 8'h00, 8'h00, 8'h00,  0, 0, 1, 1};
    ft[11] = '{12, -1, -1, -1, 1'b0, 8'h5A, 8'hA5, 8'h3C, 24, 0, 1, 1};

    repeat (4) drive(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    @(negedge clk);
    chk_all_zero("reset");
    mon_en = 1'b1;
    repeat (20) drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);

    for (int i = 0; i < NF; i++) begin
      cnt_we = 0; cnt_err = 0; cnt_fs = 0;
      gen_frame(ft[i]);
      @(negedge clk);
      chk($sformatf("f%0d_we_count", i), cnt_we, ft[i].exp_we);
      chk($sformatf("f%0d_err_count", i), cnt_err, ft[i].exp_err);
      chk($sformatf("f%0d_fs_count", i), cnt_fs, ft[i].exp_fs);
      chk($sformatf("f%0d_locked", i), {31'd0, lk1}, ft[i].exp_locked);
      if (ft[i].exp_we > 0 && ft[i].rst_line < 0) begin
        chk($sformatf("f%0d_hold", i), {x1, y1, r1, g1, b1}, {last_wr.x, last_wr.y, last_wr.r, last_wr.g, last_wr.b});
      end
    end

    chk("wq_drained", wq.size(), 0);
    chk("errq_drained", errq.size(), 0);
    chk("fsq_drained", fsq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
